// File: rtl/sram_responder.sv
// Single-port 32-bit word SRAM responder with byte enables, write-first read data and
// fixed one-cycle latency. Define SRAM_RESP_STATS_EN to build the access counters and OOB error capture.
module sram_responder #(
    parameter int ADDR_WIDTH = 14,
    parameter bit INIT_ZERO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic        stat_clr,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt,
    output logic        err_oob,
    output logic [31:0] err_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  access;
    logic [31:0]           merged;

    assign idx      = sram_addr[ADDR_WIDTH+1:2];
    assign in_range = (sram_addr[31:ADDR_WIDTH+2] == '0);
    assign access   = sram_en && !reset;

    // Post-write view of the addressed word: enabled wdata bytes over the stored bytes.
    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign merged[8*b +: 8] = sram_we[b] ? sram_wdata[8*b +: 8] : mem[idx][8*b +: 8];
    end

    if (INIT_ZERO) begin : g_init_zero
`ifndef SYNTHESIS
        initial begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end
`endif
    end

    // Array contents survive reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (access && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_rdata <= '0;
        end else if (sram_en) begin
            sram_rdata <= in_range ? merged : 32'h0;
        end
    end

`ifdef SRAM_RESP_STATS_EN
    logic [1:0] unused_bits;
    assign unused_bits = sram_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            err_oob     <= 1'b0;
            err_addr    <= '0;
        end else if (stat_clr) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            err_oob     <= 1'b0;
            err_addr    <= '0;
        end else if (sram_en) begin
            // Counters saturate rather than wrap.
            if (sram_we == 4'h0) begin
                if (stat_rd_cnt != 32'hFFFF_FFFF) stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end else begin
                if (stat_wr_cnt != 32'hFFFF_FFFF) stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end
            if (!in_range && !err_oob) begin
                err_oob  <= 1'b1;
                err_addr <= sram_addr;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{sram_addr[1:0], stat_clr};

    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
    assign err_oob     = 1'b0;
    assign err_addr    = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus random bench for sram_responder: expected read data is queued when a
// request is driven and compared one cycle later; stats are checked against a small model.
module tb_sram_responder;

    localparam int AW = 14;
`ifdef SRAM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_we = 4'h0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_wdata = '0;
    logic [31:0] sram_rdata;
    logic        stat_clr = 1'b0;
    logic [31:0] stat_rd_cnt, stat_wr_cnt, err_addr;
    logic        err_oob;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mdl [int];
    logic [31:0] exp_last = '0;
    logic [31:0] m_rd = '0, m_wr = '0, m_eaddr = '0;
    logic        m_eoob = 1'b0;

    sram_responder #(.ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .sram_en(sram_en), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
        .err_oob(err_oob), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".rd_cnt"}, stat_rd_cnt, STATS ? m_rd : 32'h0);
        check({tag, ".wr_cnt"}, stat_wr_cnt, STATS ? m_wr : 32'h0);
        check({tag, ".err_oob"}, {31'h0, err_oob}, {31'h0, STATS & m_eoob});
        check({tag, ".err_addr"}, err_addr, STATS ? m_eaddr : 32'h0);
    endtask

    // Drive one cycle of stimulus (called #1 after a rising edge), update the model,
    // then compare rdata #1 after the next rising edge.
    task automatic step(input string tag, input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd, input logic clr);
        logic [31:0] old, mrg, exp;
        logic [AW-1:0] ix;
        logic inr;
        sram_en = en; sram_we = we; sram_addr = addr; sram_wdata = wd; stat_clr = clr;
        ix  = addr[AW+1:2];
        inr = (addr >> (AW + 2)) == 0;
        old = mdl.exists(int'(ix)) ? mdl[int'(ix)] : 32'h0;
        for (int b = 0; b < 4; b++) mrg[8*b +: 8] = we[b] ? wd[8*b +: 8] : old[8*b +: 8];
        if (!en)      exp = exp_last;
        else if (inr) exp = mrg;
        else          exp = 32'h0;
        if (en && inr && we != 4'h0) mdl[int'(ix)] = mrg;
        exp_last = exp;
        exp_q.push_back(exp);
        if (clr) begin
            m_rd = 0; m_wr = 0; m_eoob = 1'b0; m_eaddr = 0;
        end else if (en) begin
            if (we == 4'h0) m_rd = m_rd + 1; else m_wr = m_wr + 1;
            if (!inr && !m_eoob) begin m_eoob = 1'b1; m_eaddr = addr; end
        end
        @(posedge clk); #1;
        if (exp_q.size() == 0) check({tag, ".q_empty"}, 32'h1, 32'h0);
        else check({tag, ".rdata"}, sram_rdata, exp_q.pop_front());
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata", sram_rdata, 32'h0);
        check_stats("reset");
        reset = 1'b0;

        // Basic write then read
        step("wr10", 1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
        check("wr10.const", sram_rdata, 32'hDEADBEEF);
        step("rd10", 1, 4'h0, 32'h10, 32'h0, 0);
        check("rd10.const", sram_rdata, 32'hDEADBEEF);
        check_stats("after_rd10");
        if (STATS) begin
            check("rd10.wr_cnt_1", stat_wr_cnt, 32'd1);
            check("rd10.rd_cnt_1", stat_rd_cnt, 32'd1);
        end

        // Partial byte write, write-first rdata
        step("pwr10", 1, 4'b0101, 32'h10, 32'h11223344, 0);
        check("pwr10.const", sram_rdata, 32'hDE22BE44);

        // Back-to-back reads, then idle hold
        step("b2b10", 1, 4'h0, 32'h10, 32'h0, 0);
        check("b2b10.const", sram_rdata, 32'hDE22BE44);
        step("b2b13", 1, 4'h0, 32'h13, 32'h0, 0);
        check("b2b13.const", sram_rdata, 32'hDE22BE44);
        step("b2b14", 1, 4'h0, 32'h14, 32'h0, 0);
        check("b2b14.const", sram_rdata, 32'h0);
        step("idle_hold", 0, 4'hF, 32'h14, 32'hFFFFFFFF, 0);
        check("idle_hold.const", sram_rdata, 32'h0);
        step("prime", 1, 4'h0, 32'h10, 32'h0, 0);
        step("idle_hold2", 0, 4'hF, 32'h10, 32'h0BADBAD0, 0);
        check("idle_hold2.const", sram_rdata, 32'hDE22BE44);

        // Out-of-range accesses
        step("oob_wr", 1, 4'hF, 32'h0001_0000, 32'h55AA55AA, 0);
        check("oob_wr.const", sram_rdata, 32'h0);
        step("oob_rd", 1, 4'h0, 32'h0002_0000, 32'h0, 0);
        check_stats("oob");
        if (STATS) begin
            check("oob.err_oob_1", {31'h0, err_oob}, 32'h1);
            check("oob.err_addr_first", err_addr, 32'h0001_0000);
        end
        step("rd0", 1, 4'h0, 32'h0, 32'h0, 0);
        check("rd0.const", sram_rdata, 32'h0);

        // Clear with a same-cycle write
        step("clr_wr20", 1, 4'hF, 32'h20, 32'hCAFEF00D, 1);
        check_stats("clr");
        if (STATS) check("clr.rd_cnt_0", stat_rd_cnt, 32'h0);
        step("rd20", 1, 4'h0, 32'h20, 32'h0, 0);
        check("rd20.const", sram_rdata, 32'hCAFEF00D);
        check_stats("after_rd20");

        // Random back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 4) == 0) ? (32'h0004_0000 | $urandom_range(0, 255))
                                            : 32'($urandom_range(0, 63));
            step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a,
                 $urandom, ($urandom_range(0, 15) == 0));
        end
        check_stats("rand");

        // Reset between two reads
        step("pre_rst", 1, 4'h0, 32'h10, 32'h0, 0);
        sram_en = 1'b1; sram_we = 4'hF; sram_addr = 32'h10; sram_wdata = 32'h0F0F0F0F;
        #2 reset = 1'b1;
        #1;
        check("rst_async.rdata", sram_rdata, 32'h0);
        check("rst_async.rd_cnt", stat_rd_cnt, 32'h0);
        check("rst_async.err_oob", {31'h0, err_oob}, 32'h0);
        @(posedge clk); #1;
        check("rst_hold.rdata", sram_rdata, 32'h0);
        reset = 1'b0;
        m_rd = 0; m_wr = 0; m_eoob = 1'b0; m_eaddr = 0; exp_last = 32'h0;
        step("post_rst10", 1, 4'h0, 32'h10, 32'h0, 0);
        step("post_rst20", 1, 4'h0, 32'h20, 32'h0, 0);
        check_stats("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 14, meaning word-index width; depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL provide parameter INIT_ZERO, default 0; when 1, the array is zero-filled at time 0 for simulation only.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL provide port sram_en, input, 1, access request this cycle.
REQ-006 SHALL provide port sram_we, input, 4, byte write enables; bit i covers bits 8i+7:8i.
REQ-007 SHALL provide port sram_addr, input, 32, byte address.
REQ-008 SHALL provide port sram_wdata, input, 32, write data.
REQ-009 SHALL provide port sram_rdata, output, 32, read data one cycle after the request.
REQ-010 SHALL provide port stat_clr, input, 1, synchronous clear of statistics.
REQ-011 SHALL provide port stat_rd_cnt, output, 32, count of accepted reads.
REQ-012 SHALL provide port stat_wr_cnt, output, 32, count of accepted writes.
REQ-013 SHALL provide port err_oob, output, 1, sticky out-of-range flag.
REQ-014 SHALL provide port err_addr, output, 32, address of the first out-of-range access.

Function
REQ-015 SHALL index the array with sram_addr[ADDR_WIDTH+1:2]; sram_addr[1:0] is ignored.
REQ-016 SHALL treat an access as out of range when any of sram_addr[31:ADDR_WIDTH+2] is nonzero.
REQ-017 SHALL, for sram_en=1, sram_we!=0 and in range, write only the enabled bytes at the edge; other bytes are unchanged.
REQ-018 SHALL, for sram_en=1 and in range, load sram_rdata at the edge with the post-write word (write-first merge of old bytes and enabled wdata bytes).
REQ-019 SHALL give fixed latency 1: data for a request in cycle N is valid in cycle N+1, with no stall and back-to-back accesses every cycle.
REQ-020 SHALL hold sram_rdata at its previous value when sram_en=0.
REQ-021 SHALL, for an out-of-range access, suppress the write and load sram_rdata with 32'h0.
REQ-022 SHALL ignore sram_we and sram_wdata when sram_en=0.
REQ-023 SHALL count an access with sram_we=0 as a read and one with sram_we!=0 as a write, including out-of-range accesses.
REQ-024 SHALL saturate both counters at 32'hFFFF_FFFF without wrapping.
REQ-025 SHALL let stat_clr take priority: in that cycle counters, err_oob and err_addr go to 0, and the same-cycle access is not counted or flagged; the memory operation still occurs.
REQ-026 SHALL set err_oob on the first out-of-range access, capture that sram_addr into err_addr, and hold both until stat_clr or reset; later out-of-range accesses do not overwrite err_addr.

Reset
REQ-027 SHALL asynchronously force sram_rdata=0, stat_rd_cnt=0, stat_wr_cnt=0, err_oob=0, err_addr=0 while reset=1.
REQ-028 SHALL ignore accesses while reset=1; array contents are not reset.
REQ-029 SHALL treat a request coincident with reset assertion as dropped, with no write and sram_rdata=0.

Configuration
REQ-030 SHALL compile the statistics and error logic (REQ-023..REQ-026) only when macro SRAM_RESP_STATS_EN is defined.
REQ-031 SHALL, without SRAM_RESP_STATS_EN, tie stat_rd_cnt, stat_wr_cnt, err_oob and err_addr to 0 and ignore stat_clr, with memory behaviour identical.

Verification
REQ-032 SHALL cover: write addr 0x0000_0010, we=4'hF, wdata 0xDEADBEEF, then read 0x10 -> next-cycle rdata 0xDEADBEEF; wr_cnt=1, rd_cnt=1.
REQ-033 SHALL cover: after REQ-032, write 0x10 with we=4'b0101 and wdata 0x11223344 -> same-access rdata 0xDE22BE44, a later read returns 0xDE22BE44.
REQ-034 SHALL cover: back-to-back reads of 0x10, 0x13 and 0x14 (0x14 never written, INIT_ZERO=1) -> rdata 0xDE22BE44, 0xDE22BE44, 0x0 in consecutive cycles; en=0 next -> rdata holds 0x0.
REQ-035 SHALL cover: write 0x0001_0000 with ADDR_WIDTH=14, then read 0x0002_0000 -> no write, rdata 0, err_oob=1, err_addr=0x0001_0000; read of 0x0 (index 0) unchanged.
REQ-036 SHALL cover: stat_clr together with a write to 0x20 -> counters 0, err_oob 0, and a later read of 0x20 returns the written data.
REQ-037 SHALL cover: reset asserted mid-stream between two reads -> outputs 0 immediately (asynchronously), and memory contents are preserved after release.
